mock1: RTL and testbench

//  1-bit ALU slice: one bit of A/B plus carry-in, 2-bit op select S1:S0, mode M
//  (0 = logic, 1 = arithmetic). Outputs function bit Fi and carry-out Cout.
//  Fi/Cout are purely combinational so slices can ripple-chain (Cout -> next Ci).

---
 rtl/mock1.sv | 105 ++++++++++
 tb/tb_mock1.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mock1.sv
// -----------------------------------------------------------------------------
// mock1 : one-bit ALU slice
//
// Computes one bit of a logic or arithmetic function of A and B. Fi and Cout
// are purely combinational, so several slices can be chained by wiring each
// slice's Cout to the next slice's Ci. Fi_q and Cout_q are registered copies
// of those outputs for synchronous consumers.
//
// Ports
//   clk     in   1  clock; used only by Fi_q/Cout_q
//   rst_n   in   1  asynchronous active-low reset; clears Fi_q/Cout_q
//   Ai      in   1  operand A bit
//   Bi      in   1  operand B bit
//   Ci      in   1  carry-in; used only in arithmetic mode
//   S1      in   1  operation select, MSB
//   S0      in   1  operation select, LSB
//   M       in   1  mode: 0 = logic, 1 = arithmetic
//   Fi      out  1  function result, combinational
//   Cout    out  1  carry-out, combinational (always 0 in logic mode)
//   Fi_q    out  1  Fi registered on posedge clk
//   Cout_q  out  1  Cout registered on posedge clk
// -----------------------------------------------------------------------------
module mock1 (
  input  logic clk,
  input  logic rst_n,
  input  logic Ai,
  input  logic Bi,
  input  logic Ci,
  input  logic S1,
  input  logic S0,
  input  logic M,
  output logic Fi,
  output logic Cout,
  output logic Fi_q,
  output logic Cout_q
);

  logic [1:0] sel_s;
  logic       y_s;
  logic       fi_s;
  logic       cout_s;
  logic       fi_r;
  logic       cout_r;

  assign sel_s = {S1, S0};

  // Full-adder sum and carry. Kept as helpers so both outputs come from the
  // same operands with no chance of the two equations drifting apart.
  function automatic logic fa_sum(input logic a, input logic b, input logic c);
    return a ^ b ^ c;
  endfunction

  function automatic logic fa_carry(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Second adder operand: B, ~B, constant 0 or constant 1, chosen by select.
  always_comb begin
    y_s = 1'b0;
    case (sel_s)
      2'b00:   y_s = Bi;
      2'b01:   y_s = ~Bi;
      2'b10:   y_s = 1'b0;
      2'b11:   y_s = 1'b1;
      default: y_s = 1'b0;
    endcase
  end

  // Result selection. In logic mode Ci is never read, so an unknown carry-in
  // cannot reach Fi or Cout.
  always_comb begin
    fi_s   = 1'b0;
    cout_s = 1'b0;
    if (M) begin
      fi_s   = fa_sum(Ai, y_s, Ci);
      cout_s = fa_carry(Ai, y_s, Ci);
    end else begin
      cout_s = 1'b0;
      case (sel_s)
        2'b00:   fi_s = Ai & Bi;
        2'b01:   fi_s = Ai | Bi;
        2'b10:   fi_s = Ai ^ Bi;
        2'b11:   fi_s = ~Ai;
        default: fi_s = 1'b0;
      endcase
    end
  end

  // Registered copies for synchronous consumers; reset clears them at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fi_r   <= 1'b0;
      cout_r <= 1'b0;
    end else begin
      fi_r   <= fi_s;
      cout_r <= cout_s;
    end
  end

  assign Fi     = fi_s;
  assign Cout   = cout_s;
  assign Fi_q   = fi_r;
  assign Cout_q = cout_r;

endmodule

// File: tb/tb_mock1.sv
// -----------------------------------------------------------------------------
// tb_mock1 : self-checking bench for the mock1 one-bit ALU slice
//
// Drives inputs shortly after a rising edge, checks the combinational outputs
// on the falling edge and the registered outputs shortly after the next
// rising edge. Expected values come from hand-computed vectors and from an
// integer-addition reference for arithmetic mode.
// -----------------------------------------------------------------------------
module tb_mock1;

  logic clk;
  logic rst_n;
  logic Ai, Bi, Ci, S1, S0, M;
  logic Fi, Cout, Fi_q, Cout_q;

  int tests_run;
  int tests_failed;

  mock1 dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .Ai     (Ai),
    .Bi     (Bi),
    .Ci     (Ci),
    .S1     (S1),
    .S0     (S0),
    .M      (M),
    .Fi     (Fi),
    .Cout   (Cout),
    .Fi_q   (Fi_q),
    .Cout_q (Cout_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic a, input logic b, input logic c,
                       input logic [1:0] s, input logic m);
    Ai = a; Bi = b; Ci = c; S1 = s[1]; S0 = s[0]; M = m;
  endtask

  // Drive one vector after a rising edge and check Fi/Cout on the falling edge.
  task automatic apply_check(input string name,
                             input logic a, input logic b, input logic c,
                             input logic [1:0] s, input logic m,
                             input logic exp_f, input logic exp_c);
    @(posedge clk);
    #1;
    drive(a, b, c, s, m);
    @(negedge clk);
    tests_run++;
    if (Fi !== exp_f || Cout !== exp_c) begin
      tests_failed++;
      $display("FAIL %s: Fi=%b Cout=%b, expected Fi=%b Cout=%b",
               name, Fi, Cout, exp_f, exp_c);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 2'b00, 1'b1);
    @(negedge clk);
    tests_run++;
    if (Fi_q !== 1'b0 || Cout_q !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: Fi_q=%b Cout_q=%b, expected 0 0", Fi_q, Cout_q);
    end
    // Combinational path runs during reset: 1+1+0 gives sum 0 carry 1.
    tests_run++;
    if (Fi !== 1'b0 || Cout !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_comb: Fi=%b Cout=%b, expected 0 1", Fi, Cout);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_logic();
    apply_check("logic_xor", 1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 1'b0);
    apply_check("logic_not", 1'b1, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0);
    apply_check("logic_and", 1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0);
    apply_check("logic_or",  1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0);
    // Unknown carry-in must not disturb logic mode.
    apply_check("logic_ci_x", 1'b1, 1'b1, 1'bx, 2'b10, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_arith();
    apply_check("add_111",  1'b1, 1'b1, 1'b1, 2'b00, 1'b1, 1'b1, 1'b1);
    apply_check("add_100",  1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0);
    // 0 + ~1 + 1 = 1 with no carry out.
    apply_check("sub_011",  1'b0, 1'b1, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0);
    apply_check("sub_111",  1'b1, 1'b1, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1);
    apply_check("inc_101",  1'b1, 1'b0, 1'b1, 2'b10, 1'b1, 1'b0, 1'b1);
    apply_check("dec_0x0",  1'b0, 1'b1, 1'b0, 2'b11, 1'b1, 1'b1, 1'b0);
    apply_check("dec_1x0",  1'b1, 1'b0, 1'b0, 2'b11, 1'b1, 1'b0, 1'b1);
  endtask

  // All 64 input combinations, plus the registered copy one edge later.
  task automatic test_exhaustive();
    logic a, b, c, m;
    logic [1:0] s;
    logic y, ef, ec;
    int sum;
    for (int v = 0; v < 64; v++) begin
      {m, s, c, b, a} = v[4:0] == 5'd0 && v[5] == 1'b0 ? 6'd0 : v[5:0];
      if (m == 1'b0) begin
        ec = 1'b0;
        if (s == 2'd0)      ef = a & b;
        else if (s == 2'd1) ef = a | b;
        else if (s == 2'd2) ef = (a != b);
        else                ef = !a;
      end else begin
        if (s == 2'd0)      y = b;
        else if (s == 2'd1) y = !b;
        else if (s == 2'd2) y = 1'b0;
        else                y = 1'b1;
        sum = int'(a) + int'(y) + int'(c);
        ef = (sum % 2) == 1;
        ec = sum >= 2;
      end
      @(posedge clk);
      #1;
      drive(a, b, c, s, m);
      @(negedge clk);
      tests_run++;
      if (Fi !== ef || Cout !== ec) begin
        tests_failed++;
        $display("FAIL exh_comb v=%0d: Fi=%b Cout=%b, expected Fi=%b Cout=%b",
                 v, Fi, Cout, ef, ec);
      end
      @(posedge clk);
      #1;
      tests_run++;
      if (Fi_q !== ef || Cout_q !== ec) begin
        tests_failed++;
        $display("FAIL exh_reg v=%0d: Fi_q=%b Cout_q=%b, expected Fi_q=%b Cout_q=%b",
                 v, Fi_q, Cout_q, ef, ec);
      end
    end
  endtask

  task automatic test_async_reset();
    // Fi=1 (1 xor 0), register it.
    @(posedge clk);
    #1;
    drive(1'b1, 1'b0, 1'b0, 2'b10, 1'b0);
    @(posedge clk);
    #1;
    tests_run++;
    if (Fi_q !== 1'b1) begin
      tests_failed++;
      $display("FAIL areset_pre: Fi_q=%b, expected 1", Fi_q);
    end
    // Assert reset mid-cycle; registered output clears without a clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (Fi_q !== 1'b0 || Fi !== 1'b1) begin
      tests_failed++;
      $display("FAIL areset_assert: Fi_q=%b Fi=%b, expected Fi_q=0 Fi=1", Fi_q, Fi);
    end
    // Held low across an edge.
    @(posedge clk);
    #1;
    tests_run++;
    if (Fi_q !== 1'b0) begin
      tests_failed++;
      $display("FAIL areset_hold: Fi_q=%b, expected 0", Fi_q);
    end
    // Release mid-cycle: nothing loads until the next rising edge.
    #2;
    rst_n = 1'b1;
    #1;
    tests_run++;
    if (Fi_q !== 1'b0) begin
      tests_failed++;
      $display("FAIL areset_release: Fi_q=%b, expected 0", Fi_q);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (Fi_q !== 1'b1 || Cout_q !== 1'b0) begin
      tests_failed++;
      $display("FAIL areset_reload: Fi_q=%b Cout_q=%b, expected 1 0", Fi_q, Cout_q);
    end
  endtask

  task automatic test_back_to_back();
    // Carry registered, then a vector with no carry on the very next edge.
    @(posedge clk);
    #1;
    drive(1'b1, 1'b1, 1'b0, 2'b00, 1'b1);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
    tests_run++;
    if (Fi_q !== 1'b0 || Cout_q !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_first: Fi_q=%b Cout_q=%b, expected 0 1", Fi_q, Cout_q);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (Fi_q !== 1'b0 || Cout_q !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_second: Fi_q=%b Cout_q=%b, expected 0 0", Fi_q, Cout_q);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    test_reset();
    test_logic();
    test_arith();
    test_exhaustive();
    test_async_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
